// File: rtl/i2c_eeprom_target.sv
// rtl/i2c_eeprom_target.sv - I2C target emulating a 256-byte 24Cxx EEPROM (page write, random/sequential read).
// Optional write protect input enabled by defining I2C_EEPROM_TARGET_WP_EN.
`timescale 1ns/1ps
module i2c_eeprom_target #(
    parameter logic [6:0] DEV_ADDR    = 7'b1010001,
    parameter int         PAGE_SIZE   = 16,
    parameter int         MEM_DEPTH   = 256,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk1,
    input  logic       reset,
`ifdef I2C_EEPROM_TARGET_WP_EN
    input  logic       wp,
`endif
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_WORD_ADDR, S_WORD_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    localparam logic [7:0] PAGE_MASK = 8'(PAGE_SIZE - 1);

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic                   wp_s;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        mem_we;
    logic [7:0]  mem_rdata_q;
    logic [7:0]  mem_q [MEM_DEPTH];
    logic [7:0]  rx_byte, page_next;

    always_ff @(posedge clk1) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

`ifdef I2C_EEPROM_TARGET_WP_EN
    logic [1:0] wp_sync_q;
    always_ff @(posedge clk1) begin
        if (reset) wp_sync_q <= 2'b00;
        else       wp_sync_q <= {wp_sync_q[0], wp};
    end
    assign wp_s = wp_sync_q[1];
`else
    assign wp_s = 1'b0;
`endif

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = ~scl_hist_q & scl_s;
    assign scl_fall  = scl_hist_q & ~scl_s;
    assign start_det = scl_hist_q & scl_s & sda_hist_q & ~sda_s;
    assign stop_det  = scl_hist_q & scl_s & ~sda_hist_q & sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};
    // Writes stay inside the current page; reads use the full 8-bit increment.
    assign page_next = (ptr_q & ~PAGE_MASK) | ((ptr_q + 8'd1) & PAGE_MASK);

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            ptr_q       <= 8'd0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 8'd0;
            wr_data_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Single-port array: the pointer location is read every cycle that is not a write.
    always_ff @(posedge clk1) begin
        if (mem_we) mem_q[ptr_q] <= rx_byte;
        else        mem_rdata_q  <= mem_q[ptr_q];
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_we      = 1'b0;
        if (start_det) begin
            state_d   = S_DEV_ADDR;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b1;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_DEV_ADDR, S_WORD_ADDR, S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (state_q == S_DEV_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    rw_d    = rx_byte[0];
                                    state_d = S_DEV_ACK;
                                end else begin
                                    state_d = S_IGNORE;
                                end
                            end else if (state_q == S_WORD_ADDR) begin
                                ptr_d   = rx_byte;
                                state_d = S_WORD_ACK;
                            end else if (wp_s) begin
                                state_d = S_IGNORE;
                            end else begin
                                mem_we      = ~reset;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                                wr_data_d   = rx_byte;
                                ptr_d       = page_next;
                                state_d     = S_WR_ACK;
                            end
                        end
                    end
                end
                S_DEV_ACK, S_WORD_ACK, S_WR_ACK: begin
                    // bit_cnt_q marks whether the ACK low is already being driven.
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d  = 1'b1;
                            bit_cnt_d = 4'd1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (state_q == S_DEV_ACK && rw_q) begin
                                state_d   = S_RD_DATA;
                                shift_d   = {mem_rdata_q[6:0], 1'b0};
                                sda_oe_d  = ~mem_rdata_q[7];
                                bit_cnt_d = 4'd1;
                            end else if (state_q == S_DEV_ACK) begin
                                state_d = S_WORD_ADDR;
                            end else begin
                                state_d = S_WR_DATA;
                            end
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = S_RD_ACK;
                        end else begin
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise && bit_cnt_q == 4'd0) begin
                        if (!sda_s) begin
                            ptr_d     = ptr_q + 8'd1;
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        state_d   = S_RD_DATA;
                        shift_d   = {mem_rdata_q[6:0], 1'b0};
                        sda_oe_d  = ~mem_rdata_q[7];
                        bit_cnt_d = 4'd1;
                    end
                end
                S_IDLE, S_IGNORE: sda_oe_d = 1'b0;
                default:          state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sda_oe    = sda_oe_q;
        busy      = busy_q;
        wr_strobe = wr_strobe_q;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
    end

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// tb/tb_i2c_eeprom_target.sv - Bus-master bench with write/read scoreboards for i2c_eeprom_target.
`timescale 1ns/1ps
module tb_i2c_eeprom_target;

    localparam int Q = 10;

    logic       clk1 = 1'b0;
    logic       reset = 1'b1;
    logic       scl_in = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe, busy, wr_strobe;
    logic [7:0] wr_addr, wr_data;
`ifdef I2C_EEPROM_TARGET_WP_EN
    logic       wp = 1'b0;
`endif

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic        oe_seen = 1'b0;

    assign sda_in = sda_m & ~sda_oe;
    always #5 clk1 = ~clk1;

    i2c_eeprom_target dut (
        .clk1      (clk1),
        .reset     (reset),
`ifdef I2C_EEPROM_TARGET_WP_EN
        .wp        (wp),
`endif
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always @(negedge clk1) begin : wr_mon
        logic [15:0] e;
        if (sda_oe) oe_seen = 1'b1;
        if (wr_strobe) begin
            n_cmp++;
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_strobe_unexpected: got addr=%h data=%h, required no strobe", wr_addr, wr_data);
            end else begin
                e = wr_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    n_fail++;
                    $display("FAIL wr_commit: got addr=%h data=%h, required addr=%h data=%h",
                             wr_addr, wr_data, e[15:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        repeat (Q) @(negedge clk1);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_in = 1'b1; tick();
        sda_m = 1'b0; tick();
        scl_in = 1'b0; tick();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; tick();
        scl_in = 1'b1; tick();
        sda_m = 1'b0; tick();
        scl_in = 1'b0; tick();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick();
        scl_in = 1'b1; tick();
        sda_m = 1'b1; tick();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; tick();
            scl_in = 1'b1; tick(); tick();
            scl_in = 1'b0; tick();
        end
        sda_m = 1'b1; tick();
        scl_in = 1'b1; tick();
        ack = sda_in; tick();
        scl_in = 1'b0; tick();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d, output logic oe_ack);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick();
            scl_in = 1'b1; tick();
            d[i] = sda_in; tick();
            scl_in = 1'b0; tick();
        end
        sda_m = nack; tick();
        scl_in = 1'b1; tick();
        oe_ack = sda_oe; tick();
        scl_in = 1'b0; tick();
        sda_m = 1'b1;
    endtask

    // Writes n consecutive values starting at b0; expected commits follow page wrap.
    task automatic do_write(input logic [7:0] wa, input logic [7:0] b0, input int n,
                            output logic [7:0] acks, output logic busy_mid);
        logic a;
        logic [7:0] ea;
        acks = 8'h00;
        i2c_start();
        write_byte(8'hA2, a); acks[0] = a;
        busy_mid = busy;
        write_byte(wa, a); acks[1] = a;
        for (int k = 0; k < n; k++) begin
            ea = {wa[7:4], 4'(wa[3:0] + k[3:0])};
            wr_q.push_back({ea, 8'(b0 + k[7:0])});
            write_byte(8'(b0 + k[7:0]), a); acks[2+k] = a;
        end
        i2c_stop();
    endtask

    task automatic do_read(input logic [7:0] wa, input logic use_addr, input int n,
                           output logic [7:0] acks, output logic [31:0] got, output logic oe_nack);
        logic a;
        logic [7:0] b;
        acks = 8'h00;
        got = 32'h0;
        i2c_start();
        if (use_addr) begin
            write_byte(8'hA2, a); acks[0] = a;
            write_byte(wa, a); acks[1] = a;
            i2c_rstart();
        end
        write_byte(8'hA3, a); acks[2] = a;
        for (int k = 0; k < n; k++) begin
            read_byte(k == n - 1, b, oe_nack);
            got[8*k +: 8] = b;
        end
        i2c_stop();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge clk1);
        n_cmp += 5;
        if (sda_oe !== 1'b0)    begin n_fail++; $display("FAIL reset_sda_oe: got %b, required 0", sda_oe); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe: got %b, required 0", wr_strobe); end
        if (wr_addr !== 8'h00)  begin n_fail++; $display("FAIL reset_wr_addr: got %h, required 00", wr_addr); end
        if (wr_data !== 8'h00)  begin n_fail++; $display("FAIL reset_wr_data: got %h, required 00", wr_data); end
        reset = 1'b0;
        repeat (5) @(negedge clk1);
    endtask

    task automatic test_single_write();
        logic [7:0] acks;
        logic bm;
        do_write(8'h0A, 8'h5C, 1, acks, bm);
        tick();
        n_cmp += 4;
        if (acks !== 8'h00) begin n_fail++; $display("FAIL single_write_acks: got %b, required 00000000", acks); end
        if (bm !== 1'b1)    begin n_fail++; $display("FAIL single_write_busy_mid: got %b, required 1", bm); end
        if (busy !== 1'b0)  begin n_fail++; $display("FAIL single_write_busy_after_stop: got %b, required 0", busy); end
        if (wr_q.size() != 0) begin n_fail++; $display("FAIL single_write_strobes: got %0d pending, required 0", wr_q.size()); end
    endtask

    task automatic test_page_write();
        logic [7:0] acks, e;
        logic [31:0] got;
        logic bm, oe;
        do_write(8'h20, 8'h77, 1, acks, bm);
        do_write(8'h1E, 8'h01, 4, acks, bm);
        tick();
        n_cmp += 2;
        if (acks !== 8'h00) begin n_fail++; $display("FAIL page_write_acks: got %b, required 00000000", acks); end
        if (wr_q.size() != 0) begin n_fail++; $display("FAIL page_write_strobes: got %0d pending, required 0", wr_q.size()); end
        rd_q.push_back(8'h01); rd_q.push_back(8'h02); rd_q.push_back(8'h77);
        do_read(8'h1E, 1'b1, 3, acks, got, oe);
        for (int k = 0; k < 3; k++) begin
            e = rd_q.pop_front();
            n_cmp++;
            if (got[8*k +: 8] !== e) begin n_fail++; $display("FAIL page_readback_%0d: got %h, required %h", k, got[8*k +: 8], e); end
        end
        rd_q.push_back(8'h03);
        do_read(8'h10, 1'b1, 1, acks, got, oe);
        e = rd_q.pop_front();
        n_cmp++;
        if (got[7:0] !== e) begin n_fail++; $display("FAIL page_wrap_byte: got %h, required %h", got[7:0], e); end
    endtask

    task automatic test_random_read();
        logic [7:0] acks, e;
        logic [31:0] got;
        logic bm, oe;
        do_write(8'h40, 8'hA5, 1, acks, bm);
        rd_q.push_back(8'hA5);
        do_read(8'h40, 1'b1, 1, acks, got, oe);
        e = rd_q.pop_front();
        n_cmp += 3;
        if (got[7:0] !== e) begin n_fail++; $display("FAIL random_read_data: got %h, required %h", got[7:0], e); end
        if (oe !== 1'b0)    begin n_fail++; $display("FAIL random_read_nack_oe: got %b, required 0", oe); end
        if (acks !== 8'h00) begin n_fail++; $display("FAIL random_read_acks: got %b, required 00000000", acks); end
    endtask

    task automatic test_seq_read_wrap();
        logic [7:0] acks, e;
        logic [31:0] got;
        logic bm, oe;
        do_write(8'hFF, 8'h11, 1, acks, bm);
        do_write(8'h00, 8'h22, 1, acks, bm);
        rd_q.push_back(8'h11); rd_q.push_back(8'h22);
        do_read(8'hFF, 1'b1, 2, acks, got, oe);
        for (int k = 0; k < 2; k++) begin
            e = rd_q.pop_front();
            n_cmp++;
            if (got[8*k +: 8] !== e) begin n_fail++; $display("FAIL seq_read_wrap_%0d: got %h, required %h", k, got[8*k +: 8], e); end
        end
    endtask

    task automatic test_addr_mismatch();
        logic a1, a2, a3;
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'hA4, a1);
        write_byte(8'h33, a2);
        i2c_stop();
        n_cmp += 3;
        if (a1 !== 1'b1)      begin n_fail++; $display("FAIL mismatch_dev_ack: got %b, required 1", a1); end
        if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL mismatch_sda_oe: got %b, required 0", oe_seen); end
        if (a2 !== 1'b1)      begin n_fail++; $display("FAIL mismatch_data_ack: got %b, required 1", a2); end
        i2c_start();
        write_byte(8'hA2, a3);
        i2c_stop();
        n_cmp++;
        if (a3 !== 1'b0) begin n_fail++; $display("FAIL mismatch_next_ack: got %b, required 0", a3); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] acks, e;
        logic [31:0] got;
        logic a, bm, oe;
        do_write(8'h50, 8'h00, 1, acks, bm);
        i2c_start();
        write_byte(8'hA2, a);
        write_byte(8'h50, a);
        i2c_rstart();
        write_byte(8'hA3, a);
        for (int i = 0; i < 3; i++) begin
            tick();
            scl_in = 1'b1; tick(); tick();
            scl_in = 1'b0; tick();
        end
        n_cmp++;
        if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL mid_read_driving: got %b, required 1", sda_oe); end
        reset = 1'b1;
        @(negedge clk1);
        n_cmp += 2;
        if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL mid_read_reset_oe: got %b, required 0", sda_oe); end
        if (busy !== 1'b0)   begin n_fail++; $display("FAIL mid_read_reset_busy: got %b, required 0", busy); end
        reset = 1'b0;
        tick();
        i2c_stop();
        do_write(8'h60, 8'h99, 1, acks, bm);
        rd_q.push_back(8'h99);
        do_read(8'h60, 1'b1, 1, acks, got, oe);
        e = rd_q.pop_front();
        n_cmp += 2;
        if (got[7:0] !== e) begin n_fail++; $display("FAIL post_reset_read: got %h, required %h", got[7:0], e); end
        if (acks !== 8'h00) begin n_fail++; $display("FAIL post_reset_acks: got %b, required 00000000", acks); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] acks, e;
        logic [31:0] got;
        logic bm, oe;
        do_write(8'h6F, 8'h12, 1, acks, bm);
        rd_q.push_back(8'h99);
        do_read(8'h00, 1'b0, 1, acks, got, oe);
        e = rd_q.pop_front();
        n_cmp += 2;
        if (got[7:0] !== e) begin n_fail++; $display("FAIL current_addr_read: got %h, required %h", got[7:0], e); end
        if (acks !== 8'h00) begin n_fail++; $display("FAIL current_addr_acks: got %b, required 00000000", acks); end
    endtask

`ifdef I2C_EEPROM_TARGET_WP_EN
    task automatic test_write_protect();
        logic a0, a1, a2;
        logic [7:0] acks, e;
        logic [31:0] got;
        logic oe;
        wp = 1'b1;
        tick();
        i2c_start();
        write_byte(8'hA2, a0);
        write_byte(8'h60, a1);
        write_byte(8'h55, a2);
        i2c_stop();
        wp = 1'b0;
        tick();
        n_cmp += 3;
        if (a0 !== 1'b0) begin n_fail++; $display("FAIL wp_dev_ack: got %b, required 0", a0); end
        if (a1 !== 1'b0) begin n_fail++; $display("FAIL wp_word_ack: got %b, required 0", a1); end
        if (a2 !== 1'b1) begin n_fail++; $display("FAIL wp_data_nack: got %b, required 1", a2); end
        rd_q.push_back(8'h99);
        do_read(8'h60, 1'b1, 1, acks, got, oe);
        e = rd_q.pop_front();
        n_cmp++;
        if (got[7:0] !== e) begin n_fail++; $display("FAIL wp_mem_unchanged: got %h, required %h", got[7:0], e); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_page_write();
        test_random_read();
        test_seq_read_wrap();
        test_addr_mismatch();
        test_reset_mid_read();
        test_back_to_back();
`ifdef I2C_EEPROM_TARGET_WP_EN
        test_write_protect();
`endif
        tick();
        n_cmp++;
        if (wr_q.size() != 0 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got wr=%0d rd=%0d pending, required 0", wr_q.size(), rd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
